bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 204 ++++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multi-digit 7-segment driver: sequential double-dabble binary-to-BCD conversion
// behind a valid/busy handshake, saturation to all-nines, and time-multiplexed
// digit scanning with optional leading-zero blanking.
module bcd_scan_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DATA_W         = 14,
    parameter int unsigned REFRESH_CYCLES = 250_000,
    parameter int unsigned BLANK_LZ       = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              DATA_VALID,
    output logic              BUSY,
    output logic              OVERFLOW,
    output logic [6:0]        SEGMENTS,
    output logic [DIGITS-1:0] DIGIT_EN
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    // Largest displayable value, 10^DIGITS - 1.
    function automatic longint unsigned max_value(input int unsigned n);
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < n; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    localparam logic [31:0]      MAX_VAL   = 32'(max_value(DIGITS));
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'd9}};
    localparam logic [6:0]       RESET_SEG = (SEG_ACTIVE_LOW != 0) ? 7'b0000001 : 7'b1111110;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_flag_q;
    logic               busy_q;
    logic [BCD_W-1:0]   disp_q;
    logic               overflow_q;

    logic [31:0]        data_ext;
    logic               data_over;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;

    // Overflow decision and one double-dabble step (add-3 then shift in next bit).
    always_comb begin
        data_ext  = 32'(DATA_IN);
        data_over = (data_ext > MAX_VAL);
        bcd_adj   = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // Top bit of the scratch register falls off here.
        bcd_shift = {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
    end

    // Converter FSM with registered BUSY, display register and OVERFLOW.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            data_q     <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (DATA_VALID) begin
                        data_q     <= DATA_IN;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        ovf_flag_q <= data_over;
                        busy_q     <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    bcd_q  <= bcd_shift;
                    data_q <= {data_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= StCommit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCommit: begin
                    disp_q     <= ovf_flag_q ? ALL_NINES : bcd_q;
                    overflow_q <= ovf_flag_q;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign OVERFLOW = overflow_q;

    // Active-high segment code for one BCD nibble; non-decimal nibbles go blank.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [REF_W-1:0]  ref_q;
    logic [REF_W-1:0]  ref_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [DIGITS-1:0] en_q;
    logic [DIGITS-1:0] en_d;
    logic [6:0]        seg_q;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] zero_above;
    logic              zero_acc;
    logic [3:0]        nib_sel;
    logic              blank_sel;

    // Refresh counter, digit index and the segment pattern for the next enabled digit.
    always_comb begin
        if (ref_q == REF_W'(REFRESH_CYCLES - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            ref_d = ref_q + 1'b1;
            idx_d = idx_q;
        end

        // zero_above[i]: nibbles i..DIGITS-1 are all zero.
        zero_acc = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_acc      = zero_acc && (disp_q[4*i +: 4] == 4'd0);
            zero_above[i] = zero_acc;
        end

        nib_sel   = disp_q[3:0];
        blank_sel = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_sel   = disp_q[4*i +: 4];
                blank_sel = (BLANK_LZ != 0) && (i != 0) && zero_above[i];
            end
        end

        seg_d = blank_sel ? 7'b0000000 : seg_code(nib_sel);
        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
        end
        en_d = DIGITS'(1) << idx_d;
    end

    // Scan registers; SEGMENTS and DIGIT_EN change on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ref_q <= '0;
            idx_q <= '0;
            en_q  <= DIGITS'(1);
            seg_q <= RESET_SEG;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
            en_q  <= en_d;
            seg_q <= seg_d;
        end
    end

    assign SEGMENTS = seg_q;
    assign DIGIT_EN = en_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: three instances (blanking, no blanking,
// active-low segments) share stimulus; table of loads plus handshake/reset sequences.
module tb_bcd_scan_display;

    localparam logic [6:0] C0 = 7'b1111110;
    localparam logic [6:0] C1 = 7'b0110000;
    localparam logic [6:0] C2 = 7'b1101101;
    localparam logic [6:0] C3 = 7'b1111001;
    localparam logic [6:0] C4 = 7'b0110011;
    localparam logic [6:0] C5 = 7'b1011011;
    localparam logic [6:0] C7 = 7'b1110000;
    localparam logic [6:0] C8 = 7'b1111111;
    localparam logic [6:0] C9 = 7'b1110011;
    localparam logic [6:0] CB = 7'b0000000;

    logic        CLK;
    logic        RESET_N;
    logic [13:0] DATA_IN;
    logic        DATA_VALID;

    logic       busy_m, busy_n, busy_a;
    logic       ovf_m, ovf_n, ovf_a;
    logic [6:0] seg_m, seg_n, seg_a;
    logic [3:0] en_m, en_n, en_a;

    bcd_scan_display #(.DIGITS(4), .DATA_W(14), .REFRESH_CYCLES(4), .BLANK_LZ(1),
                       .SEG_ACTIVE_LOW(0)) u_main (
        .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .BUSY(busy_m), .OVERFLOW(ovf_m), .SEGMENTS(seg_m), .DIGIT_EN(en_m)
    );

    bcd_scan_display #(.DIGITS(4), .DATA_W(14), .REFRESH_CYCLES(4), .BLANK_LZ(0),
                       .SEG_ACTIVE_LOW(0)) u_noblank (
        .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .BUSY(busy_n), .OVERFLOW(ovf_n), .SEGMENTS(seg_n), .DIGIT_EN(en_n)
    );

    bcd_scan_display #(.DIGITS(4), .DATA_W(14), .REFRESH_CYCLES(4), .BLANK_LZ(1),
                       .SEG_ACTIVE_LOW(1)) u_actlow (
        .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .BUSY(busy_a), .OVERFLOW(ovf_a), .SEGMENTS(seg_a), .DIGIT_EN(en_a)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [13:0] val;
        logic [27:0] seg_blank;  // {d3,d2,d1,d0} with leading-zero blanking
        logic [27:0] seg_full;   // {d3,d2,d1,d0} without blanking
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    int n_vec  = 0;
    int n_miss = 0;

    logic [6:0] cap_m[4];
    logic [6:0] cap_n[4];
    logic [6:0] cap_a[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy_m && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 200) fail_now("idle_wait");
    endtask

    // Present a one-cycle load request, then count the cycles BUSY stays high.
    task automatic load(input logic [13:0] v, output int busy_cycles);
        wait_idle();
        DATA_IN    = v;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        busy_cycles = 0;
        while (busy_m && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge CLK);
        end
    endtask

    // Record the pattern shown on each digit over one full frame.
    task automatic capture();
        int bad_oh;
        bad_oh = 0;
        for (int d = 0; d < 4; d++) begin
            cap_m[d] = 'x;
            cap_n[d] = 'x;
            cap_a[d] = 'x;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            for (int d = 0; d < 4; d++) begin
                if (en_m[d]) cap_m[d] = seg_m;
                if (en_n[d]) cap_n[d] = seg_n;
                if (en_a[d]) cap_a[d] = seg_a;
            end
            if (!$onehot(en_m)) bad_oh++;
        end
        chk("en_onehot", 32'(bad_oh), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [27:0] eb, input logic [27:0] ef,
                               input logic ovf);
        logic [6:0] exp_b;
        logic [6:0] exp_f;
        logic [6:0] exp_a;
        for (int d = 0; d < 4; d++) begin
            exp_b = eb[7*d +: 7];
            exp_f = ef[7*d +: 7];
            exp_a = ~exp_b;
            chk($sformatf("%s_blank_d%0d", tag, d), 32'(cap_m[d]), 32'(exp_b));
            chk($sformatf("%s_full_d%0d", tag, d), 32'(cap_n[d]), 32'(exp_f));
            chk($sformatf("%s_actlow_d%0d", tag, d), 32'(cap_a[d]), 32'(exp_a));
        end
        chk($sformatf("%s_overflow", tag), 32'(ovf_m), 32'(ovf));
    endtask

    initial begin
        int bc;
        int idx;

        vecs[0]  = '{14'd1234,  {C1, C2, C3, C4}, {C1, C2, C3, C4}, 1'b0};
        vecs[1]  = '{14'd12345, {C9, C9, C9, C9}, {C9, C9, C9, C9}, 1'b1};
        vecs[2]  = '{14'd0,     {CB, CB, CB, C0}, {C0, C0, C0, C0}, 1'b0};
        vecs[3]  = '{14'd7,     {CB, CB, CB, C7}, {C0, C0, C0, C7}, 1'b0};
        vecs[4]  = '{14'd8,     {CB, CB, CB, C8}, {C0, C0, C0, C8}, 1'b0};
        vecs[5]  = '{14'd9999,  {C9, C9, C9, C9}, {C9, C9, C9, C9}, 1'b0};
        vecs[6]  = '{14'd10000, {C9, C9, C9, C9}, {C9, C9, C9, C9}, 1'b1};
        vecs[7]  = '{14'd16383, {C9, C9, C9, C9}, {C9, C9, C9, C9}, 1'b1};
        vecs[8]  = '{14'd40,    {CB, CB, C4, C0}, {C0, C0, C4, C0}, 1'b0};
        vecs[9]  = '{14'd1005,  {C1, C0, C0, C5}, {C1, C0, C0, C5}, 1'b0};
        vecs[10] = '{14'd250,   {CB, C2, C5, C0}, {C0, C2, C5, C0}, 1'b0};
        vecs[11] = '{14'd5,     {CB, CB, CB, C5}, {C0, C0, C0, C5}, 1'b0};

        RESET_N    = 1'b0;
        DATA_IN    = '0;
        DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        #1;

        // Reset state.
        chk("rst_en", 32'(en_m), 32'b0001);
        chk("rst_seg", 32'(seg_m), 32'(C0));
        chk("rst_seg_actlow", 32'(seg_a), 32'b0000001);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_ovf", 32'(ovf_m), 32'd0);

        // Scan rotation: 4 cycles per digit, digits 1..3 blank for value 0.
        for (int n = 1; n <= 17; n++) begin
            @(negedge CLK);
            idx = (n / 4) % 4;
            chk($sformatf("rot%0d_en", n), 32'(en_m), 32'(4'b0001 << idx));
            chk($sformatf("rot%0d_seg", n), 32'(seg_m), (idx == 0) ? 32'(C0) : 32'(CB));
        end

        // Table of loads.
        for (int k = 0; k < 12; k++) begin
            load(vecs[k].val, bc);
            chk($sformatf("v%0d_busy_cycles", k), 32'(bc), 32'd15);
            @(negedge CLK);
            capture();
            check_frame($sformatf("v%0d", k), vecs[k].seg_blank, vecs[k].seg_full, vecs[k].ovf);
        end

        // Load 1234 and pulse 9999 on the 5th busy cycle: the second request is dropped.
        wait_idle();
        DATA_IN    = 14'd1234;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        bc = 0;
        while (busy_m && bc < 100) begin
            bc++;
            if (bc == 5) begin
                DATA_IN    = 14'd9999;
                DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        DATA_VALID = 1'b0;
        chk("drop_busy_cycles", 32'(bc), 32'd15);
        repeat (3) @(negedge CLK);
        chk("drop_no_queue", 32'(busy_m), 32'd0);
        capture();
        check_frame("drop", {C1, C2, C3, C4}, {C1, C2, C3, C4}, 1'b0);

        // Load 40 and reset mid-shift: display goes back to 0 and never shows 40.
        wait_idle();
        DATA_IN    = 14'd40;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        chk("abort_busy_before", 32'(busy_m), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("abort_busy_in_reset", 32'(busy_m), 32'd0);
        chk("abort_en_in_reset", 32'(en_m), 32'b0001);
        chk("abort_seg_in_reset", 32'(seg_m), 32'(C0));
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        chk("abort_busy_after", 32'(busy_m), 32'd0);
        capture();
        check_frame("abort", {CB, CB, CB, C0}, {C0, C0, C0, C0}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
